// File: rtl/ddr_line_pkg.sv
// ddr_line_pkg: shared widths, types and FSM encoding
// for the byte-to-line DDR adapter.
package ddr_line_pkg;

  localparam int LINE_BYTES = 64;
  localparam int OFFSET_W   = 6;
  localparam int LINE_W     = 8 * LINE_BYTES;

  typedef logic [LINE_W-1:0]     line_t;
  typedef logic [LINE_BYTES-1:0] mask_t;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    RD_REQ,
    RD_WAIT
  } adapter_state_e;

  function automatic logic [7:0] line_byte(
    input line_t               l,
    input logic [OFFSET_W-1:0] off
  );
    return l[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ddr_line_buf.sv
// ddr_line_buf: one cached DDR line plus its per-byte
// dirty mask; byte write, full-line load, byte read.
module ddr_line_buf
  import ddr_line_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [OFFSET_W-1:0] wr_off_i,
  input  logic [7:0]          wr_byte_i,
  input  logic                load_en_i,
  input  line_t               load_line_i,
  input  logic                dirty_clr_i,
  input  logic [OFFSET_W-1:0] rd_off_i,
  output logic [7:0]          rd_byte_o,
  output line_t               line_o,
  output mask_t               dirty_o
);

  line_t line_q, line_d;
  mask_t dirty_q, dirty_d;

  always_comb begin
    line_d  = line_q;
    dirty_d = dirty_q;
    if (load_en_i) begin
      line_d  = load_line_i;
      dirty_d = '0;
    end
    if (dirty_clr_i) begin
      dirty_d = '0;
    end
    if (wr_en_i) begin
      line_d[{wr_off_i, 3'b000} +: 8] = wr_byte_i;
      dirty_d[wr_off_i]               = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q  <= '0;
      dirty_q <= '0;
    end else begin
      line_q  <= line_d;
      dirty_q <= dirty_d;
    end
  end

  assign rd_byte_o = line_byte(line_q, rd_off_i);
  assign line_o    = line_q;
  assign dirty_o   = dirty_q;

endmodule

// File: rtl/ddr_byte_line_adapter.sv
// ddr_byte_line_adapter: single-line write-back buffer
// between a byte-wide AVMM host and a 512-bit DDR agent.
module ddr_byte_line_adapter #(
  parameter int ADDR_W     = 33,
  parameter int LINE_BYTES = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_W-1:0]       a_address_i,
  input  logic                    a_read_i,
  input  logic                    a_write_i,
  input  logic [7:0]              a_writedata_i,
  output logic                    a_waitrequest_o,
  output logic [7:0]              a_readdata_o,
  output logic                    a_readdatavalid_o,
  output logic [ADDR_W-1:0]       h_address_o,
  output logic                    h_read_o,
  output logic                    h_write_o,
  output logic [8*LINE_BYTES-1:0] h_writedata_o,
  output logic [LINE_BYTES-1:0]   h_byteenable_o,
  input  logic                    h_waitrequest_i,
  input  logic [8*LINE_BYTES-1:0] h_readdata_i,
  input  logic                    h_readdatavalid_i,
  input  logic                    flush_i,
  output logic                    flush_done_o
);

  import ddr_line_pkg::*;

  localparam int TAG_W = ADDR_W - OFFSET_W;

  adapter_state_e state_q, state_d;

  logic [TAG_W-1:0] line_tag_q, line_tag_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d;
  logic             line_valid_q, line_valid_d;
  logic             flush_pend_q, flush_pend_d;
  logic             flush_done_q, flush_done_d;
  logic             rvalid_q, rvalid_d;
  logic [7:0]       rdata_q, rdata_d;

  logic [OFFSET_W-1:0] a_off;
  logic [TAG_W-1:0]    a_tag;
  logic                a_req;
  logic                hit;
  logic                serve;

  line_t      line;
  mask_t      dirty;
  logic [7:0] rd_byte;
  logic       buf_wr;
  logic       buf_load;
  logic       buf_clr;

  assign a_off = a_address_i[OFFSET_W-1:0];
  assign a_tag = a_address_i[ADDR_W-1:OFFSET_W];
  assign a_req = a_read_i | a_write_i;
  assign hit   = line_valid_q && (a_tag == line_tag_q);
  assign serve = (state_q == IDLE) && !flush_pend_q && hit;

  assign a_waitrequest_o = a_req && !serve;

  ddr_line_buf u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_en_i     (buf_wr),
    .wr_off_i    (a_off),
    .wr_byte_i   (a_writedata_i),
    .load_en_i   (buf_load),
    .load_line_i (h_readdata_i),
    .dirty_clr_i (buf_clr),
    .rd_off_i    (a_off),
    .rd_byte_o   (rd_byte),
    .line_o      (line),
    .dirty_o     (dirty)
  );

  always_comb begin
    state_d      = state_q;
    line_tag_d   = line_tag_q;
    line_valid_d = line_valid_q;
    req_tag_d    = req_tag_q;
    flush_pend_d = flush_pend_q | flush_i;
    flush_done_d = 1'b0;
    rvalid_d     = 1'b0;
    rdata_d      = rdata_q;
    buf_wr       = 1'b0;
    buf_load     = 1'b0;
    buf_clr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // a pending flush always wins over the agent
        if (flush_pend_q) begin
          if (|dirty) begin
            state_d = WB;
          end else begin
            flush_done_d = 1'b1;
            flush_pend_d = flush_i;
          end
        end else if (a_req) begin
          if (hit) begin
            if (a_write_i) begin
              buf_wr = 1'b1;
            end else begin
              rvalid_d = 1'b1;
              rdata_d  = rd_byte;
            end
          end else begin
            req_tag_d = a_tag;
            state_d   = (|dirty) ? WB : RD_REQ;
          end
        end
      end
      WB: begin
        if (!h_waitrequest_i) begin
          buf_clr = 1'b1;
          if (flush_pend_q) begin
            flush_done_d = 1'b1;
            flush_pend_d = flush_i;
            state_d      = IDLE;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (!h_waitrequest_i) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (h_readdatavalid_i) begin
          buf_load     = 1'b1;
          line_tag_d   = req_tag_q;
          line_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      line_tag_q   <= '0;
      req_tag_q    <= '0;
      line_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      line_tag_q   <= line_tag_d;
      req_tag_q    <= req_tag_d;
      line_valid_q <= line_valid_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  // host side is a pure decode of registered state
  always_comb begin
    h_read_o       = (state_q == RD_REQ);
    h_write_o      = (state_q == WB);
    h_address_o    = '0;
    h_writedata_o  = '0;
    h_byteenable_o = '0;
    unique case (state_q)
      WB: begin
        h_address_o    = {line_tag_q, {OFFSET_W{1'b0}}};
        h_writedata_o  = line;
        h_byteenable_o = dirty;
      end
      RD_REQ: begin
        h_address_o    = {req_tag_q, {OFFSET_W{1'b0}}};
        h_byteenable_o = '1;
      end
      default: ;
    endcase
  end

  assign a_readdata_o      = rdata_q;
  assign a_readdatavalid_o = rvalid_q;
  assign flush_done_o      = flush_done_q;

endmodule
